mem_reader: RTL and testbench

Memory-mapped result reader for the calculator interface. After the keypad writer has deposited operand A, operator and operand B into shared RAM, this block polls the done flag word, fetches the result word, and clears the flag so the next operation can proceed. It sits between the shared data RAM read/write port and the display/formatting logic.

---
 rtl/mem_reader_pkg.sv | 26 ++
 rtl/mem_reader_latency_counter.sv | 27 ++
 rtl/mem_reader.sv | 123 ++++++++++++
 tb/tb_mem_reader.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_reader_pkg.sv
// Shared definitions for the calculator result reader: FSM states,
// default shared-RAM word addresses and keypad writer constants.
package mem_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_WAIT,
    RES_REQ,
    RES_WAIT,
    CLEAR
  } state_t;

  localparam int unsigned ADDR_OPER   = 0;
  localparam int unsigned ADDR_A      = 4;
  localparam int unsigned ADDR_B      = 8;
  localparam int unsigned ADDR_RESULT = 12;
  localparam int unsigned ADDR_DONE   = 16;

  localparam int unsigned DONE_BIT = 0;
  localparam int unsigned POLL_W   = 10;

  // Code the keypad writer emits when no key is pressed.
  localparam logic [4:0] NO_KEY = 5'd16;

endpackage

// File: rtl/mem_reader_latency_counter.sv
// Down-counter timing the RAM read latency; zero marks the cycle in which
// read data is valid. Shared by the status poll and the result fetch.
module latency_counter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic zero
);

  logic [2:0] cnt;

  // Loaded during the request cycle, so the wait state sees LATENCY-1 down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 3'(LATENCY - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 3'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_reader.sv
// Polls the done flag in shared RAM, fetches the result word and clears the
// flag so the keypad writer can start the next operation.
module mem_reader
  import mem_reader_pkg::*;
#(
  parameter int unsigned RESULT_ADDR = ADDR_RESULT,
  parameter int unsigned DONE_ADDR   = ADDR_DONE,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned MAX_POLLS   = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] rdata,
  output logic [31:0] address,
  output logic        rd_en,
  output logic        wr_en,
  output logic [31:0] wdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        timeout,
  output logic        busy
);

  state_t            state, state_n;
  logic [POLL_W-1:0] poll_cnt;
  logic              lat_load, lat_zero;
  logic              poll_clr, poll_inc, capture, timeout_n;

  latency_counter #(.LATENCY(RD_LATENCY)) u_lat (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lat_load),
    .zero  (lat_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      poll_cnt <= '0;
      address  <= '0;
      result   <= '0;
      timeout  <= 1'b0;
    end else begin
      state   <= state_n;
      timeout <= timeout_n;
      if (poll_clr) begin
        poll_cnt <= '0;
      end else if (poll_inc) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
      if (capture) begin
        result <= rdata;
      end
      // Address is set on entry to an access state and held otherwise.
      if (state_n == POLL_REQ || state_n == CLEAR) begin
        address <= 32'(DONE_ADDR);
      end else if (state_n == RES_REQ) begin
        address <= 32'(RESULT_ADDR);
      end
    end
  end

  always_comb begin
    state_n      = state;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    result_valid = 1'b0;
    lat_load     = 1'b0;
    poll_clr     = 1'b0;
    poll_inc     = 1'b0;
    capture      = 1'b0;
    timeout_n    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = POLL_REQ;
          poll_clr = 1'b1;
        end
      end
      POLL_REQ: begin
        rd_en    = 1'b1;
        poll_inc = 1'b1;
        lat_load = 1'b1;
        state_n  = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (lat_zero) begin
          // poll_cnt already counts the poll whose data is being sampled.
          if (rdata[DONE_BIT]) begin
            state_n = RES_REQ;
          end else if (poll_cnt >= POLL_W'(MAX_POLLS)) begin
            timeout_n = 1'b1;
            state_n   = IDLE;
          end else begin
            state_n = POLL_REQ;
          end
        end
      end
      RES_REQ: begin
        rd_en    = 1'b1;
        lat_load = 1'b1;
        state_n  = RES_WAIT;
      end
      RES_WAIT: begin
        if (lat_zero) begin
          capture = 1'b1;
          state_n = CLEAR;
        end
      end
      CLEAR: begin
        wr_en        = 1'b1;
        result_valid = 1'b1;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wdata = '0;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_reader.sv
// Bench for mem_reader: two instances (read latency 1 and 3, four polls max)
// against a behavioural RAM; result/timeout events are scoreboarded.
module tb_mem_reader;

  localparam int MAXP = 4;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int W    = 49;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start        [2];
  logic [31:0] rdata        [2];
  logic [31:0] address      [2];
  logic        rd_en        [2];
  logic        wr_en        [2];
  logic [31:0] wdata        [2];
  logic [31:0] result       [2];
  logic        result_valid [2];
  logic        timeout      [2];
  logic        busy         [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // RAM model state, per instance
  int          polls   [2];
  int          rd16    [2];
  int          rd12    [2];
  int          wr16    [2];
  int          bad_wr  [2];
  int          flag_at [2];
  logic [31:0] status_lo [2];
  logic [31:0] res_val [2];
  int          due     [2];
  logic [31:0] pend    [2];
  logic        pend_v  [2];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_reader #(.RESULT_ADDR(12), .DONE_ADDR(16), .RD_LATENCY(LAT0), .MAX_POLLS(MAXP)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .rdata(rdata[0]), .address(address[0]),
    .rd_en(rd_en[0]), .wr_en(wr_en[0]), .wdata(wdata[0]), .result(result[0]),
    .result_valid(result_valid[0]), .timeout(timeout[0]), .busy(busy[0])
  );

  mem_reader #(.RESULT_ADDR(12), .DONE_ADDR(16), .RD_LATENCY(LAT1), .MAX_POLLS(MAXP)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .rdata(rdata[1]), .address(address[1]),
    .rd_en(rd_en[1]), .wr_en(wr_en[1]), .wdata(wdata[1]), .result(result[1]),
    .result_valid(result_valid[1]), .timeout(timeout[1]), .busy(busy[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? LAT0 : LAT1;
  endfunction

  // ---------------- RAM model ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) begin
        if (address[i] == 32'd16) begin
          polls[i]++;
          rd16[i]++;
          pend[i] = (flag_at[i] != 0 && polls[i] >= flag_at[i]) ? 32'h1 : status_lo[i];
        end else if (address[i] == 32'd12) begin
          rd12[i]++;
          pend[i] = res_val[i];
        end else begin
          pend[i] = 32'hBAD0_0001;
        end
        pend_v[i] = 1'b1;
        due[i]    = cyc + lat(i);
      end
      if (wr_en[i]) begin
        if (address[i] == 32'd16 && wdata[i] == 32'd0) wr16[i]++;
        else bad_wr[i]++;
      end
      if (rd_en[i] && wr_en[i]) bad_wr[i]++;
    end
  end

  // Data is valid only in the exact latency cycle; otherwise junk with bit 0 set.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (pend_v[i] && due[i] == cyc) begin
        rdata[i]  = pend[i];
        pend_v[i] = 1'b0;
      end else begin
        rdata[i] = 32'hDEAD_BEEF;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int i, input logic kind, input int at, input logic [31:0] v);
    logic [15:0] c;
    c = 16'(at);
    if (i == 0) exp_q0.push_back({kind, c, v});
    else        exp_q1.push_back({kind, c, v});
  endtask

  task automatic got_event(input int i, input logic kind, input logic [31:0] val);
    logic [W-1:0] a, e;
    a = {kind, cyc[15:0], val};
    checks++;
    if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event dut%0d actual=%h expected=none", i, a);
    end else begin
      e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (a !== e) begin
        failures++;
        $display("FAIL event dut%0d actual(kind,cyc,val)=%h expected=%h", i, a, e);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (result_valid[i]) got_event(i, 1'b0, result[i]);
      if (timeout[i])      got_event(i, 1'b1, result[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic setup(input int i, input int fa, input logic [31:0] lo, input logic [31:0] rv);
    flag_at[i]   = fa;
    status_lo[i] = lo;
    res_val[i]   = rv;
    polls[i]     = 0;
    rd16[i]      = 0;
    rd12[i]      = 0;
    wr16[i]      = 0;
    bad_wr[i]    = 0;
  endtask

  // Returns the cycle counter value during the first cycle after start is sampled.
  task automatic do_start(input int i, output int s);
    @(posedge clk); #1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    s = cyc;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    while (busy[i] && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", {31'd0, busy[i]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag, input int i, input int e16, input int e12, input int ew);
    chk({tag, "_rd16"}, 32'(rd16[i]), 32'(e16));
    chk({tag, "_rd12"}, 32'(rd12[i]), 32'(e12));
    chk({tag, "_wr16"}, 32'(wr16[i]), 32'(ew));
    chk({tag, "_badwr"}, 32'(bad_wr[i]), 32'd0);
  endtask

  task automatic chk_zero(input string tag, input int i);
    chk({tag, "_address"}, address[i], 32'd0);
    chk({tag, "_rd_en"}, {31'd0, rd_en[i]}, 32'd0);
    chk({tag, "_wr_en"}, {31'd0, wr_en[i]}, 32'd0);
    chk({tag, "_wdata"}, wdata[i], 32'd0);
    chk({tag, "_result"}, result[i], 32'd0);
    chk({tag, "_result_valid"}, {31'd0, result_valid[i]}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout[i]}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy[i]}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    start  = '{default: 1'b0};
    rdata  = '{default: 32'hDEAD_BEEF};
    pend_v = '{default: 1'b0};
    pend   = '{default: 32'd0};
    due    = '{default: 0};
    setup(0, 0, 32'd0, 32'd0);
    setup(1, 0, 32'd0, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset0", 0);
    chk_zero("reset1", 1);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // flag ready on first poll, best-case timing
    setup(0, 1, 32'd0, 32'h0000_002A);
    do_start(0, s);
    expect_ev(0, 1'b0, s + 4, 32'h0000_002A);
    wait_idle(0, 40);
    chk_counts("first_poll", 0, 1, 1, 1);
    chk("first_poll_result", result[0], 32'd42);

    // flag ready on third poll
    setup(0, 3, 32'd0, 32'h1234_5678);
    do_start(0, s);
    expect_ev(0, 1'b0, s + 8, 32'h1234_5678);
    wait_idle(0, 40);
    chk_counts("third_poll", 0, 3, 1, 1);

    // flag never set: timeout after MAX_POLLS, result held
    setup(0, 0, 32'd0, 32'h0000_0099);
    do_start(0, s);
    expect_ev(0, 1'b1, s + 8, 32'h1234_5678);
    wait_idle(0, 40);
    chk_counts("timeout", 0, 4, 0, 0);
    chk("timeout_result_held", result[0], 32'h1234_5678);

    // latency 3, only bit 0 of the status word matters
    setup(1, 2, 32'hFFFF_FFFE, 32'hCAFE_F00D);
    do_start(1, s);
    expect_ev(1, 1'b0, s + 12, 32'hCAFE_F00D);
    wait_idle(1, 60);
    chk_counts("lat3", 1, 2, 1, 1);
    chk("lat3_result", result[1], 32'hCAFE_F00D);

    // extra start while busy and during CLEAR is ignored
    setup(0, 1, 32'd0, 32'h0000_0077);
    do_start(0, s);
    expect_ev(0, 1'b0, s + 4, 32'h0000_0077);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("ignored_start_busy_c6", {31'd0, busy[0]}, 32'd0);
    @(posedge clk); #1;
    chk("ignored_start_busy_c7", {31'd0, busy[0]}, 32'd0);
    wait_idle(0, 40);
    chk_counts("ignored_start", 0, 1, 1, 1);

    // async reset during RES_WAIT aborts without a flag clear
    setup(0, 1, 32'd0, 32'h0000_0055);
    do_start(0, s);
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset", 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_counts("mid_reset", 0, 1, 1, 0);

    // fresh transaction after reset release
    setup(0, 1, 32'd0, 32'hA5A5_0F0F);
    do_start(0, s);
    expect_ev(0, 1'b0, s + 4, 32'hA5A5_0F0F);
    wait_idle(0, 40);
    chk_counts("after_reset", 0, 1, 1, 1);
    chk("after_reset_result", result[0], 32'hA5A5_0F0F);

    repeat (5) @(posedge clk);
    #1;
    chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
